// File: rtl/fsm3_steer_tx.sv
// fsm3_steer_tx: inverse driver for the 3-state Moore FSM (W/X/Y, y=1 only in X).
// Takes a word of desired y bits over a valid/ready handshake. It serialises the word into the
// x stream that makes the downstream FSM produce exactly those y bits. It does this by tracking
// a model of the FSM state.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   load_valid/ready    word handshake; load_ready is combinational
//   load_data           desired y bits (WIDTH)
//   sync                resynchronise model to W when no bit is emitted on that edge
//   x_out               registered steering bit for the FSM x input
//   x_valid, x_last     x_out is live / x_out is the final bit of a word
//   y_model             predicted FSM y after x_out is consumed (1 iff model is X)
module fsm3_steer_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sync,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last,
  output logic             y_model
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] ModW = 2'b00;
  localparam logic [1:0] ModX = 2'b01;
  localparam logic [1:0] ModY = 2'b10;

  typedef enum logic {StIdle, StShift} ctrl_e;

  ctrl_e             ctrl_q, ctrl_d;
  logic [1:0]        model_q, model_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              x_out_q, x_out_d;
  logic              x_valid_q, x_valid_d;
  logic              x_last_q, x_last_d;
  logic              y_model_q, y_model_d;

  logic              accept, mid, emit, bit_d, enc_x;
  logic [1:0]        m_base, m_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= StIdle;
      model_q   <= ModW;
      shift_q   <= '0;
      cnt_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      y_model_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      model_q   <= model_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
      y_model_q <= y_model_d;
    end
  end

  // Next-state logic
  always_comb begin
    ctrl_d    = ctrl_q;
    model_d   = model_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
    x_last_d  = x_last_q;
    y_model_d = y_model_q;

    accept = load_valid & load_ready;
    // A bit of the current word still has to go out on this edge.
    mid    = (ctrl_q == StShift) & ~x_last_q;
    emit   = accept | mid;

    // sync only applies when no mid-word bit is going out; with an accept it seeds the encoder.
    m_base = (sync & ~mid) ? ModW : model_q;

    if (accept) begin
      bit_d = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    end else begin
      bit_d = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    end

    // From W the y=1 successor is reached with x=1; from X and Y it needs x=0.
    enc_x = ((m_base == ModX) || (m_base == ModY)) ? ~bit_d : bit_d;

    case (m_base)
      ModX:    m_next = enc_x ? ModY : ModX;
      ModY:    m_next = enc_x ? ModW : ModX;
      default: m_next = enc_x ? ModX : ModY;  // W, and illegal 2'b11 treated as W
    endcase

    if (emit) begin
      ctrl_d    = StShift;
      x_out_d   = enc_x;
      model_d   = m_next;
      y_model_d = (m_next == ModX);
      x_valid_d = 1'b1;
      if (accept) begin
        shift_d = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
        cnt_d   = CntW'(1);
      end else begin
        shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        cnt_d   = cnt_q + CntW'(1);
      end
      x_last_d = (cnt_d == CntW'(WIDTH));
    end else begin
      if (ctrl_q == StShift) begin
        ctrl_d    = StIdle;
        x_valid_d = 1'b0;
        x_last_d  = 1'b0;
        cnt_d     = '0;
      end
      if (sync) begin
        model_d   = ModW;
        y_model_d = 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    load_ready = (ctrl_q == StIdle) | x_last_q;
    x_out      = x_out_q;
    x_valid    = x_valid_q;
    x_last     = x_last_q;
    y_model    = y_model_q;
  end

endmodule

// File: tb/tb_fsm3_steer_tx.sv
module tb_fsm3_steer_tx;

  localparam int unsigned W   = 8;
  localparam bit          MSB = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data = '0;
  logic         sync = 1'b0;
  logic         x_out, x_valid, x_last, y_model;

  fsm3_steer_tx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sync       (sync),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .x_last     (x_last),
    .y_model    (y_model)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: either a resync marker or one expected y bit.
  typedef struct packed {bit mark; bit y; bit last;} exp_t;

  exp_t queue_q[$];
  bit   xlog[$];
  int   checks   = 0;
  int   failures = 0;
  int   rem      = 0;   // bits of the accepted word still to be emitted on later edges
  bit   exp_valid = 1'b0;

  // Reference FSM as a transition table: state 0=W, 1=X, 2=Y; y=1 only in X.
  int   ref_st = 0;
  int   nxt_tab[3][2] = '{'{2, 1}, '{1, 2}, '{1, 0}};

  // Monitor: independent of the driver except through the scoreboard queue.
  always @(negedge clk) begin
    if (rst) begin
      ref_st = 0;
    end else begin
      checks++;
      if (x_valid !== exp_valid) begin
        failures++;
        $display("FAIL x_valid: got %b want %b at %0t", x_valid, exp_valid, $time);
      end
      if (x_valid === 1'b1) begin
        while (queue_q.size() > 0 && queue_q[0].mark) begin
          void'(queue_q.pop_front());
          ref_st = 0;
        end
        checks++;
        if (queue_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bit: got x_valid=1 want empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          e = queue_q.pop_front();
          xlog.push_back(x_out);
          ref_st = nxt_tab[ref_st][x_out ? 1 : 0];
          if (((ref_st == 1) !== e.y) || (y_model !== e.y) || (x_last !== e.last)) begin
            failures++;
            $display("FAIL bit: got fsm_y=%b y_model=%b x_last=%b want y=%b last=%b at %0t",
                     ref_st == 1, y_model, x_last, e.y, e.last, $time);
          end
        end
      end else if (x_last !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL x_last_idle: got %b want 0 at %0t", x_last, $time);
      end
    end
  end

  // One clock of driving; inputs are already set. Predicts ready/valid from the TB's own count.
  task automatic cycle(output bit acc);
    bit emit;
    checks++;
    if (load_ready !== (rem == 0)) begin
      failures++;
      $display("FAIL load_ready: got %b want %b at %0t", load_ready, rem == 0, $time);
    end
    acc = load_valid && (rem == 0);
    if (sync && rem == 0) queue_q.push_back('{mark: 1'b1, y: 1'b0, last: 1'b0});
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        exp_t e;
        e.mark = 1'b0;
        e.y    = MSB ? load_data[W-1-i] : load_data[i];
        e.last = (i == W - 1);
        queue_q.push_back(e);
      end
    end
    emit = acc || (rem > 0);
    if (acc) rem = W - 1;
    else if (rem > 0) rem--;
    @(posedge clk);
    #1;
    exp_valid = emit;
  endtask

  task automatic idle(input int n);
    bit a;
    load_valid = 1'b0;
    sync = 1'b0;
    repeat (n) cycle(a);
  endtask

  task automatic load_word(input logic [W-1:0] d);
    bit a;
    load_valid = 1'b1;
    load_data  = d;
    cycle(a);
    load_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic check_x(input string name, input logic [15:0] want, input int n);
    logic [15:0] got;
    got = '0;
    for (int i = 0; i < xlog.size() && i < 16; i++) got = {got[14:0], xlog[i]};
    checks++;
    if (xlog.size() != n || got != want) begin
      failures++;
      $display("FAIL %s: got %0d bits %h want %0d bits %h", name, xlog.size(), got, n, want);
    end
    xlog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    queue_q.delete();
    rem = 0;
    exp_valid = 1'b0;
    checks++;
    if (x_valid !== 1'b0 || x_last !== 1'b0 || y_model !== 1'b0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b y=%b r=%b want v=0 l=0 y=0 r=1",
               x_valid, x_last, y_model, load_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    xlog.delete();
  endtask

  initial begin
    bit a;
    bit pend;
    @(posedge clk);
    #1;
    do_reset();
    checks++;
    if (x_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_x_out: got %b want 0", x_out);
    end

    // 8'hAA from reset
    load_word(8'hAA);
    idle(10);
    check_x("aa_from_w", 16'h00D5, 8);

    // sync in idle (model was Y), then 8'h80 encoded from W
    sync = 1'b1;
    cycle(a);
    sync = 1'b0;
    checks++;
    if (y_model !== 1'b0) begin
      failures++;
      $display("FAIL sync_y_model: got %b want 0", y_model);
    end
    load_word(8'h80);
    idle(10);
    check_x("x80_after_sync", 16'h00EA, 8);

    // 8'hAA leaves model Y; 8'h80 without sync
    load_word(8'hAA);
    idle(10);
    xlog.delete();
    load_word(8'h80);
    idle(10);
    check_x("x80_from_y", 16'h006A, 8);

    // FF then 00 back to back, with sync to start from W
    sync = 1'b1;
    load_word(8'hFF);
    load_valid = 1'b1;
    load_data  = 8'h00;
    pend = 1'b1;
    for (int i = 0; i < 2 * W && pend; i++) begin
      cycle(a);
      if (a) pend = 1'b0;
    end
    idle(12);
    check_x("ff_then_00", 16'h80D5, 16);

    // 0F held during mid-word SHIFT
    sync = 1'b1;
    load_word(8'hAA);
    load_valid = 1'b1;
    load_data  = 8'h0F;
    pend = 1'b1;
    for (int i = 0; i < 2 * W && pend; i++) begin
      cycle(a);
      if (a) pend = 1'b0;
    end
    idle(12);
    xlog.delete();

    // Reset after 3 bits of 8'hAA, then 8'hAA again
    load_word(8'hAA);
    idle(2);
    #2;
    do_reset();
    load_word(8'hAA);
    idle(10);
    check_x("aa_after_reset", 16'h00D5, 8);

    // Randomised streaming with held words and sync noise
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        load_valid = ($urandom_range(0, 9) < 7);
        load_data  = W'($urandom());
        pend = load_valid;
      end
      sync = ($urandom_range(0, 9) == 0);
      cycle(a);
      if (a) pend = 1'b0;
    end
    idle(W + 4);

    checks++;
    if (queue_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries want 0", queue_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm3_steer_tx.md
Name: fsm3_steer_tx

Overview:
- Inverse driver for the team's 3-state Moore FSM (states W/X/Y, output y; y=1 only in X).
- Accepts a parallel word of desired y bits over a valid/ready handshake and serialises it into the x input stream that steers that FSM.
- Tracks an internal model of the FSM state so the driven FSM produces exactly the requested y sequence.
- Sits upstream of the FSM as its stimulus/transmit end.

Parameters:
- WIDTH, 8, number of desired-y bits per loaded word (>=2).
- MSB_FIRST, 1, 1 = send load_data[WIDTH-1] first; 0 = send bit 0 first.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  load_data valid.
- load_ready  output  1  block can accept a word this cycle (combinational).
- load_data  input  WIDTH  desired y bits.
- sync  input  1  forces model state to W (resynchronise to a freshly reset FSM).
- x_out  output  1  steering bit for the FSM x input (registered).
- x_valid  output  1  x_out carries a live bit (registered).
- x_last  output  1  high with the final bit of a word (registered).
- y_model  output  1  predicted FSM y after x_out is applied; 1 iff model=X (registered).

Behaviour:
- Reset (async): ctrl=IDLE, model=W, x_out=0, x_valid=0, x_last=0, y_model=0, shift register and bit counter cleared.
- Model encoding: W=2'b00, X=2'b01, Y=2'b10. Code 2'b11 is illegal and is treated as W for encoding and next-state.
- FSM transitions being modelled:
  - W: x=1 -> X; x=0 -> Y.
  - X: x=1 -> Y; x=0 -> X.
  - Y: x=1 -> W; x=0 -> X.
- Encoding rule: each state has exactly one successor with y=1 and one with y=0, so for desired bit d:
  - m=W: x=d.
  - m=X: x=~d.
  - m=Y: x=~d.
  - Model then moves to the successor selected by that x.
- Control states:
  - IDLE: load_ready=1.
  - SHIFT: load_ready=1 only on the cycle x_last=1 (back-to-back streaming, no gap); otherwise 0.
- Accept: on the edge where load_valid & load_ready:
  - x_out <= enc(model, first bit); model <= next.
  - x_valid <= 1; counter <= 1; remaining bits are stored; ctrl=SHIFT.
- Each following edge presents the next bit in the same way.
- Bit WIDTH is presented with x_last=1.
- On the edge after x_last with no new accept: x_valid=0, x_last=0, ctrl=IDLE.
  - x_out holds its last value.
  - Model and y_model hold.
- Latency: first x bit valid the cycle after accept. A word occupies exactly WIDTH consecutive x_valid cycles.
- Back-to-back: an accept on the x_last cycle makes the new word's first bit follow with no bubble, encoded from the updated model.
- sync:
  - Honoured only when no bit is being emitted on that edge (IDLE, or last cycle with no new accept): model <= W, y_model <= 0.
  - sync together with an accept on the same edge: the first bit is encoded from W.
  - sync during mid-word SHIFT is ignored.
- load_valid while load_ready=0: ignored. The word must be held by the sender until accepted.
- Reset mid-word: all outputs drop to reset values immediately (async); the partial word is discarded.
- y_model always equals the y the driven FSM reports after consuming x_out.

Test Plan:
- Reset, load 8'hAA (MSB_FIRST=1) -> x_out = 1,1,0,1,0,1,0,1 over 8 x_valid cycles; y_model = 1,0,1,0,1,0,1,0; x_last on the 8th; final model Y.
- From reset, load 8'hFF -> x = 1,0,0,0,0,0,0,0, y_model all 1, model X. Then load 8'h00 on the x_last cycle -> no gap, x = 1,1,0,1,0,1,0,1, y_model all 0, model W.
- From reset, load 8'h00 -> x = 0,1,0,1,0,1,0,1, model ends W.
- After 8'hAA (model Y), pulse sync in IDLE, load 8'h80 -> x = 1,1,1,0,1,0,1,0. Same load without sync -> x = 0,1,1,0,1,0,1,0.
- Assert rst after 3 bits of 8'hAA -> x_valid=0, x_last=0, y_model=0, load_ready=1 the same cycle. Next load 8'hAA reproduces the first scenario exactly.
- Hold load_valid with 8'h0F during mid-word SHIFT -> not accepted until the x_last cycle. Scoreboard: a reference FSM fed x_out must match y_model every x_valid cycle.
